// File: rtl/dag_circ.sv
// Data address generator: two DAGs, each with NREG sets of I/M/L/B registers,
// circular-buffer wrap, pre/post-modify addressing and bit-reversed output.
module dag_circ #(
    parameter int DW    = 16,
    parameter int NREG  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps_dg_en,
    input  logic             ps_dg_dgsclt,
    input  logic             ps_dg_mdfy,
    input  logic             ps_dg_brev,
    input  logic [IDX_W-1:0] ps_dg_iadd,
    input  logic [IDX_W-1:0] ps_dg_madd,
    input  logic             ps_dg_wrt_en,
    input  logic [IDX_W+2:0] ps_dg_wrt_add,
    input  logic [IDX_W+2:0] ps_dg_rd_add,
    input  logic [DW-1:0]    bc_dt,
    output logic [DW-1:0]    dg_dm_add,
    output logic [DW-1:0]    dg_ps_add,
    output logic             dg_dm_vld,
    output logic             dg_ps_vld,
    output logic [DW-1:0]    dg_bc_dt
);

    localparam logic [1:0] TYPE_I = 2'b00;
    localparam logic [1:0] TYPE_M = 2'b01;
    localparam logic [1:0] TYPE_L = 2'b10;
    localparam logic [1:0] TYPE_B = 2'b11;

    logic [DW-1:0] i_reg [2][NREG];
    logic [DW-1:0] m_reg [2][NREG];
    logic [DW-1:0] l_reg [2][NREG];
    logic [DW-1:0] b_reg [2][NREG];

    logic             wr_dag;
    logic [1:0]       wr_type;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_dag;
    logic [1:0]       rd_type;
    logic [IDX_W-1:0] rd_idx;

    assign wr_dag  = ps_dg_wrt_add[IDX_W+2];
    assign wr_type = ps_dg_wrt_add[IDX_W+1:IDX_W];
    assign wr_idx  = ps_dg_wrt_add[IDX_W-1:0];
    assign rd_dag  = ps_dg_rd_add[IDX_W+2];
    assign rd_type = ps_dg_rd_add[IDX_W+1:IDX_W];
    assign rd_idx  = ps_dg_rd_add[IDX_W-1:0];

    // Address datapath always works on pre-edge register contents.
    logic [DW-1:0] cur_i, cur_m, cur_l, cur_b;
    logic [DW-1:0] sum, lim, wrapped, pre_rev, addr, rd_data;

    assign cur_i = i_reg[ps_dg_dgsclt][ps_dg_iadd];
    assign cur_m = m_reg[ps_dg_dgsclt][ps_dg_madd];
    assign cur_l = l_reg[ps_dg_dgsclt][ps_dg_iadd];
    assign cur_b = b_reg[ps_dg_dgsclt][ps_dg_iadd];
    assign sum   = cur_i + cur_m;
    assign lim   = cur_b + cur_l;

    always_comb begin
        wrapped = sum;
        if (cur_l != '0) begin
            if (!cur_m[DW-1]) begin
                if (sum >= lim) wrapped = sum - cur_l;
            end else if (sum < cur_b) begin
                wrapped = sum + cur_l;
            end
        end
    end

    assign pre_rev = ps_dg_mdfy ? wrapped : cur_i;

    always_comb begin
        addr = pre_rev;
        if (ps_dg_brev) begin
            for (int k = 0; k < DW; k++) addr[k] = pre_rev[DW-1-k];
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_type)
            TYPE_I:  rd_data = i_reg[rd_dag][rd_idx];
            TYPE_M:  rd_data = m_reg[rd_dag][rd_idx];
            TYPE_L:  rd_data = l_reg[rd_dag][rd_idx];
            default: rd_data = b_reg[rd_dag][rd_idx];
        endcase
    end

    // The bus write is issued after the post-modify update so that, when both
    // target the same I register, the write is the assignment that sticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NREG; k++) begin
                    i_reg[d][k] <= '0;
                    m_reg[d][k] <= '0;
                    l_reg[d][k] <= '0;
                    b_reg[d][k] <= '0;
                end
            end
        end else begin
            if (ps_dg_en && !ps_dg_mdfy) i_reg[ps_dg_dgsclt][ps_dg_iadd] <= wrapped;
            if (ps_dg_wrt_en) begin
                case (wr_type)
                    TYPE_I:  i_reg[wr_dag][wr_idx] <= bc_dt;
                    TYPE_M:  m_reg[wr_dag][wr_idx] <= bc_dt;
                    TYPE_L:  l_reg[wr_dag][wr_idx] <= bc_dt;
                    default: b_reg[wr_dag][wr_idx] <= bc_dt;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dg_dm_add <= '0;
            dg_ps_add <= '0;
            dg_dm_vld <= 1'b0;
            dg_ps_vld <= 1'b0;
            dg_bc_dt  <= '0;
        end else begin
            dg_dm_vld <= ps_dg_en && !ps_dg_dgsclt;
            dg_ps_vld <= ps_dg_en && ps_dg_dgsclt;
            if (ps_dg_en && !ps_dg_dgsclt) dg_dm_add <= addr;
            if (ps_dg_en && ps_dg_dgsclt)  dg_ps_add <= addr;
            dg_bc_dt <= rd_data;
        end
    end

endmodule

// File: tb/tb_dag_circ.sv
// Self-checking bench for dag_circ: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the register sets.
module tb_dag_circ;
    localparam int DW = 16, NREG = 8, IDX_W = 3;

    logic clk = 1'b0, reset = 1'b1;
    logic ps_dg_en = 0, ps_dg_dgsclt = 0, ps_dg_mdfy = 0, ps_dg_brev = 0;
    logic [2:0] ps_dg_iadd = 0, ps_dg_madd = 0;
    logic ps_dg_wrt_en = 0;
    logic [5:0] ps_dg_wrt_add = 0, ps_dg_rd_add = 0;
    logic [15:0] bc_dt = 0;
    logic [15:0] dg_dm_add, dg_ps_add, dg_bc_dt;
    logic dg_dm_vld, dg_ps_vld;

    int errors = 0, checks = 0;

    logic [15:0] mi [2][8];
    logic [15:0] mm [2][8];
    logic [15:0] ml [2][8];
    logic [15:0] mb [2][8];
    logic [15:0] exp_dm, exp_ps;

    dag_circ #(.DW(DW), .NREG(NREG), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt),
        .ps_dg_mdfy(ps_dg_mdfy), .ps_dg_brev(ps_dg_brev), .ps_dg_iadd(ps_dg_iadd),
        .ps_dg_madd(ps_dg_madd), .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
        .ps_dg_rd_add(ps_dg_rd_add), .bc_dt(bc_dt), .dg_dm_add(dg_dm_add), .dg_ps_add(dg_ps_add),
        .dg_dm_vld(dg_dm_vld), .dg_ps_vld(dg_ps_vld), .dg_bc_dt(dg_bc_dt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] mdl_read(input logic [5:0] a);
        case (a[4:3])
            2'd0:    return mi[a[5]][a[2:0]];
            2'd1:    return mm[a[5]][a[2:0]];
            2'd2:    return ml[a[5]][a[2:0]];
            default: return mb[a[5]][a[2:0]];
        endcase
    endfunction

    task automatic model_write(input logic d, input logic [1:0] t, input logic [2:0] k, input logic [15:0] v);
        case (t)
            2'd0: mi[d][k] = v;
            2'd1: mm[d][k] = v;
            2'd2: ml[d][k] = v;
            default: mb[d][k] = v;
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 8; k++) begin
                mi[d][k] = 0; mm[d][k] = 0; ml[d][k] = 0; mb[d][k] = 0;
            end
        exp_dm = 0;
        exp_ps = 0;
    endtask

    function automatic int wrap_sum(input int i, input int m, input int l, input int b);
        int s;
        s = (i + m) & 'hFFFF;
        if (l == 0) return s;
        if (m >= 0) return (s >= ((b + l) & 'hFFFF)) ? ((s - l) & 'hFFFF) : s;
        return (s < b) ? ((s + l) & 'hFFFF) : s;
    endfunction

    function automatic logic [15:0] reverse16(input logic [15:0] v);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = v[15-k];
        return r;
    endfunction

    // Applies one generate request to the model; returns the emitted address.
    task automatic model_gen(input logic d, input logic mdfy, input logic brev,
                             input logic [2:0] ia, input logic [2:0] ma, output logic [15:0] a);
        int m, w;
        m = (mm[d][ma] >= 16'h8000) ? int'(mm[d][ma]) - 65536 : int'(mm[d][ma]);
        w = wrap_sum(int'(mi[d][ia]), m, int'(ml[d][ia]), int'(mb[d][ia]));
        a = mdfy ? w[15:0] : mi[d][ia];
        if (brev) a = reverse16(a);
        if (!mdfy) mi[d][ia] = w[15:0];
        if (d) exp_ps = a; else exp_dm = a;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_gen(input logic d, input logic mdfy, input logic brev,
                             input logic [2:0] ia, input logic [2:0] ma);
        logic [15:0] a;
        ps_dg_en = 1; ps_dg_dgsclt = d; ps_dg_mdfy = mdfy; ps_dg_brev = brev;
        ps_dg_iadd = ia; ps_dg_madd = ma;
        model_gen(d, mdfy, brev, ia, ma, a);
    endtask

    task automatic write_reg(input logic d, input logic [1:0] t, input logic [2:0] k, input logic [15:0] v);
        ps_dg_wrt_en = 1; ps_dg_wrt_add = {d, t, k}; bc_dt = v;
        @(negedge clk);
        ps_dg_wrt_en = 0;
        model_write(d, t, k, v);
    endtask

    task automatic read_reg(input logic [5:0] a, output logic [15:0] v);
        ps_dg_en = 0;
        ps_dg_rd_add = a;
        @(negedge clk);
        v = dg_bc_dt;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [15:0] v;
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if ({dg_dm_add, dg_ps_add, dg_bc_dt, dg_dm_vld, dg_ps_vld} !== 50'd0) begin
            errors++; $display("FAIL reset_async got dm=%h ps=%h bc=%h vld=%b%b required all 0",
                               dg_dm_add, dg_ps_add, dg_bc_dt, dg_dm_vld, dg_ps_vld);
        end
        for (int j = 0; j < 3; j++) begin
            ps_dg_en = 1; ps_dg_dgsclt = j[0]; ps_dg_wrt_en = 1; ps_dg_wrt_add = 6'd3; bc_dt = 16'hBEEF;
            @(negedge clk);
            checks++;
            if ({dg_dm_add, dg_ps_add, dg_bc_dt, dg_dm_vld, dg_ps_vld} !== 50'd0) begin
                errors++; $display("FAIL reset_held cyc=%0d got dm=%h ps=%h bc=%h vld=%b%b required all 0",
                                   j, dg_dm_add, dg_ps_add, dg_bc_dt, dg_dm_vld, dg_ps_vld);
            end
        end
        ps_dg_en = 0; ps_dg_wrt_en = 0;
        reset = 1;
        model_reset();
        read_reg({1'b0, 2'd0, 3'd3}, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++; $display("FAIL reset_read_i3 got=%h required=0000", v);
        end
    endtask

    task automatic test_linear();
        logic [15:0] v;
        write_reg(0, 2'd0, 3'd0, 16'h0010);
        write_reg(0, 2'd1, 3'd1, 16'h0004);
        write_reg(0, 2'd2, 3'd0, 16'h0000);
        for (int j = 0; j < 3; j++) begin
            drive_gen(0, 0, 0, 3'd0, 3'd1);
            @(negedge clk);
            checks++;
            if (dg_dm_add !== 16'(16'h0010 + 4 * j) || dg_dm_vld !== 1'b1 || dg_ps_vld !== 1'b0) begin
                errors++; $display("FAIL linear_addr%0d got=%h vld=%b%b required=%h vld=10",
                                   j, dg_dm_add, dg_dm_vld, dg_ps_vld, 16'(16'h0010 + 4 * j));
            end
        end
        read_reg({1'b0, 2'd0, 3'd0}, v);
        checks++;
        if (v !== 16'h001C || dg_dm_vld !== 1'b0) begin
            errors++; $display("FAIL linear_i0 got=%h vld=%b required=001C vld=0", v, dg_dm_vld);
        end
    endtask

    task automatic test_circular();
        logic [15:0] v, want [3];
        want[0] = 16'h0103; want[1] = 16'h0100; want[2] = 16'h0102;
        write_reg(0, 2'd3, 3'd2, 16'h0100);
        write_reg(0, 2'd2, 3'd2, 16'h0005);
        write_reg(0, 2'd0, 3'd2, 16'h0103);
        write_reg(0, 2'd1, 3'd3, 16'h0002);
        for (int j = 0; j < 3; j++) begin
            drive_gen(0, 0, 0, 3'd2, 3'd3);
            @(negedge clk);
            checks++;
            if (dg_dm_add !== want[j] || dg_dm_add !== exp_dm) begin
                errors++; $display("FAIL circ_fwd%0d got=%h required=%h", j, dg_dm_add, want[j]);
            end
        end
        ps_dg_en = 0;
        write_reg(0, 2'd0, 3'd2, 16'h0100);
        write_reg(0, 2'd1, 3'd3, 16'hFFFE);
        drive_gen(0, 0, 0, 3'd2, 3'd3);
        @(negedge clk);
        checks++;
        if (dg_dm_add !== 16'h0100) begin
            errors++; $display("FAIL circ_bwd_addr got=%h required=0100", dg_dm_add);
        end
        read_reg({1'b0, 2'd0, 3'd2}, v);
        checks++;
        if (v !== 16'h0103) begin
            errors++; $display("FAIL circ_bwd_i2 got=%h required=0103", v);
        end
    endtask

    task automatic test_premodify();
        logic [15:0] v, dm_before;
        write_reg(1, 2'd0, 3'd1, 16'h0020);
        write_reg(1, 2'd1, 3'd0, 16'h0008);
        dm_before = dg_dm_add;
        drive_gen(1, 1, 0, 3'd1, 3'd0);
        @(negedge clk);
        checks++;
        if (dg_ps_add !== 16'h0028 || dg_ps_vld !== 1'b1 || dg_dm_vld !== 1'b0 || dg_dm_add !== dm_before) begin
            errors++; $display("FAIL premod got ps=%h vld=%b%b dm=%h required ps=0028 vld=01 dm=%h",
                               dg_ps_add, dg_dm_vld, dg_ps_vld, dg_dm_add, dm_before);
        end
        read_reg({1'b1, 2'd0, 3'd1}, v);
        checks++;
        if (v !== 16'h0020 || dg_ps_vld !== 1'b0) begin
            errors++; $display("FAIL premod_i1 got=%h vld=%b required=0020 vld=0", v, dg_ps_vld);
        end
    endtask

    task automatic test_brev();
        logic [15:0] v;
        write_reg(0, 2'd0, 3'd0, 16'h0001);
        write_reg(0, 2'd1, 3'd0, 16'h0001);
        drive_gen(0, 0, 1, 3'd0, 3'd0);
        @(negedge clk);
        checks++;
        if (dg_dm_add !== 16'h8000) begin
            errors++; $display("FAIL brev_addr got=%h required=8000", dg_dm_add);
        end
        ps_dg_brev = 0;
        read_reg({1'b0, 2'd0, 3'd0}, v);
        checks++;
        if (v !== 16'h0002) begin
            errors++; $display("FAIL brev_i0 got=%h required=0002", v);
        end
    endtask

    task automatic test_collision_reset();
        logic [15:0] v;
        write_reg(0, 2'd0, 3'd0, 16'h0010);
        write_reg(0, 2'd1, 3'd1, 16'h0004);
        drive_gen(0, 0, 0, 3'd0, 3'd1);
        ps_dg_wrt_en = 1; ps_dg_wrt_add = {1'b0, 2'd0, 3'd0}; bc_dt = 16'h0050;
        ps_dg_rd_add = {1'b0, 2'd0, 3'd0};
        @(negedge clk);
        ps_dg_wrt_en = 0;
        model_write(0, 2'd0, 3'd0, 16'h0050);
        checks++;
        if (dg_dm_add !== 16'h0010 || dg_bc_dt !== 16'h0010) begin
            errors++; $display("FAIL collide_addr got=%h rd=%h required=0010 rd=0010 (old I0)", dg_dm_add, dg_bc_dt);
        end
        read_reg({1'b0, 2'd0, 3'd0}, v);
        checks++;
        if (v !== 16'h0050) begin
            errors++; $display("FAIL collide_i0 got=%h required=0050", v);
        end
        drive_gen(0, 0, 0, 3'd0, 3'd1);
        @(negedge clk);
        checks++;
        if (dg_dm_add !== 16'h0050 || dg_dm_vld !== 1'b1) begin
            errors++; $display("FAIL midrun_addr got=%h vld=%b required=0050 vld=1", dg_dm_add, dg_dm_vld);
        end
        #1;
        reset = 0;
        #1;
        checks++;
        if ({dg_dm_add, dg_ps_add, dg_bc_dt, dg_dm_vld, dg_ps_vld} !== 50'd0) begin
            errors++; $display("FAIL midrun_reset got dm=%h ps=%h bc=%h vld=%b%b required all 0",
                               dg_dm_add, dg_ps_add, dg_bc_dt, dg_dm_vld, dg_ps_vld);
        end
        @(negedge clk);
        ps_dg_en = 0;
        reset = 1;
        model_reset();
        read_reg({1'b0, 2'd0, 3'd0}, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++; $display("FAIL midrun_i0 got=%h required=0000", v);
        end
    endtask

    task automatic test_random();
        logic [15:0] l, b, exp_rd;
        logic en, d;
        for (int dd = 0; dd < 2; dd++)
            for (int k = 0; k < 8; k++) begin
                l = (k == 7) ? 16'd0 : 16'($urandom_range(8, 64));
                b = 16'($urandom_range(0, 16'hF000));
                write_reg(dd[0], 2'd2, k[2:0], l);
                write_reg(dd[0], 2'd3, k[2:0], b);
                write_reg(dd[0], 2'd0, k[2:0], (l == 0) ? 16'($urandom) : 16'(b + $urandom_range(0, int'(l) - 1)));
                write_reg(dd[0], 2'd1, k[2:0], 16'($urandom_range(0, 16) - 8));
            end
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            ps_dg_rd_add = 6'($urandom);
            exp_rd = mdl_read(ps_dg_rd_add);
            if (en) drive_gen(d, 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
            else ps_dg_en = 0;
            @(negedge clk);
            checks++;
            if (dg_dm_add !== exp_dm || dg_ps_add !== exp_ps || dg_bc_dt !== exp_rd ||
                dg_dm_vld !== (en && !d) || dg_ps_vld !== (en && d)) begin
                errors++; $display("FAIL random n=%0d got dm=%h ps=%h rd=%h vld=%b%b required dm=%h ps=%h rd=%h vld=%b%b",
                                   n, dg_dm_add, dg_ps_add, dg_bc_dt, dg_dm_vld, dg_ps_vld,
                                   exp_dm, exp_ps, exp_rd, en && !d, en && d);
            end
        end
        ps_dg_en = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_linear();
        test_circular();
        test_premodify();
        test_brev();
        test_collision_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
